// File: rtl/key_pkg.sv
// Shared definitions for the key loader and the key-gated cores that consume its bus.
package key_pkg;

    localparam int KEY_W_DEFAULT = 14;
    localparam int KEY_MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOADED = 2'd2,
        ERROR  = 2'd3
    } key_ld_state_t;

    // Callers zero-extend narrower keys; zero padding leaves the parity untouched.
    function automatic logic even_parity_ok(input logic [KEY_MAX_W-1:0] vec, input logic pbit);
        return ~(^vec ^ pbit);
    endfunction

endpackage

// File: rtl/key_wdog.sv
// Idle-cycle watchdog: a saturating 16-bit count of enabled cycles since the last clear.
module key_wdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the idle cycle whose edge brings the count to the limit, so the abort lands on that edge.
    assign expired_o = en_i && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/key_serial_loader.sv
// Bit-serial key receiver: collects KEY_W bits plus an even-parity bit and commits them to k.
module key_serial_loader
    import key_pkg::*;
#(
    parameter int KEY_W       = KEY_W_DEFAULT,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             key_start,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    input  logic             key_clear,
    output logic [0:KEY_W-1] k,
    output logic             key_ready,
    output logic             key_err,
    output logic             core_rst,
    output logic             busy
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

    key_ld_state_t        state_q;
    logic [0:KEY_W-1]     shreg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [0:KEY_W-1]     k_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 core_rst_q;
    logic                 busy_q;

    logic                 wd_clr;
    logic                 wd_en;
    logic                 timeout;
    logic                 par_ok;
    logic [KEY_MAX_W-1:0] par_vec;

    always_comb begin
        par_vec = '0;
        par_vec[KEY_W-1:0] = shreg_q;
    end

    assign par_ok = even_parity_ok(par_vec, key_bit);
    assign wd_en  = (state_q == SHIFT) && !key_bit_valid && !key_start && !key_clear;
    assign wd_clr = !wd_en;

    key_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(timeout)
    );

    always_ff @(posedge CLK) begin
        if (RST || key_clear) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_start) begin
                        state_q <= SHIFT;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (key_start) begin
                        shreg_q <= '0;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (key_bit_valid) begin
                        if (cnt_q != CNT_LAST) begin
                            shreg_q[cnt_q[IDX_W-1:0]] <= key_bit;
                            cnt_q                     <= cnt_q + CNT_W'(1);
                        end else if (par_ok) begin
                            state_q <= LOADED;
                            k_q     <= shreg_q;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                LOADED: begin
                    if (key_start) begin
                        state_q    <= SHIFT;
                        shreg_q    <= '0;
                        cnt_q      <= '0;
                        ready_q    <= 1'b0;
                        core_rst_q <= 1'b1;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        // Release the core one cycle after the key became visible.
                        core_rst_q <= 1'b0;
                    end
                end
                ERROR: begin
                    if (key_start) begin
                        state_q <= SHIFT;
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign k         = k_q;
    assign key_ready = ready_q;
    assign key_err   = err_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed bench: stimulus queues time-stamped expected output snapshots, a monitor checks every output change.
module tb_key_serial_loader;

    logic        CLK;
    logic        RST;
    logic        key_start;
    logic        key_bit_valid;
    logic        key_bit;
    logic        key_clear;
    logic [0:13] k;
    logic        key_ready;
    logic        key_err;
    logic        core_rst;
    logic        busy;

    key_serial_loader #(
        .KEY_W      (14),
        .TIMEOUT_CYC(8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .key_start    (key_start),
        .key_bit_valid(key_bit_valid),
        .key_bit      (key_bit),
        .key_clear    (key_clear),
        .k            (k),
        .key_ready    (key_ready),
        .key_err      (key_err),
        .core_rst     (core_rst),
        .busy         (busy)
    );

    typedef struct {
        int          cyc;
        logic [17:0] v;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [17:0] last_v = 'x;

    logic [0:13] ek;
    logic        er, ee, ec, eb;

    logic [0:13] K1 = 14'b00110011000100;
    logic [0:13] K2 = 14'b10000000000001;
    logic [0:13] K3 = 14'b11111111111110;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required under 100000", $time);
        $fatal(1, "bench timeout");
    end

    // Queue the current expected outputs as the state the DUT must show d cycles from now.
    task automatic push(input int d);
        exp_t        e;
        logic [17:0] s;
        s = {ek, er, ee, ec, eb};
        if (s !== last_v) begin
            e.cyc = cyc + d;
            e.v   = s;
            sbq.push_back(e);
            last_v = s;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_start();
        key_start = 1'b1;
        er = 1'b0; ec = 1'b1; ee = 1'b0; eb = 1'b1;
        push(1);
        tick();
        key_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        key_bit_valid = 1'b1;
        key_bit       = b;
        tick();
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
    endtask

    task automatic send_bits(input logic [0:13] v, input int from, input int to);
        for (int i = from; i <= to; i++) send_bit(v[i]);
    endtask

    task automatic finish_parity(input logic [0:13] v, input logic p, input logic ok);
        key_bit_valid = 1'b1;
        key_bit       = p;
        if (ok) begin
            ek = v; er = 1'b1; eb = 1'b0;
            push(1);
            ec = 1'b0;
            push(2);
        end else begin
            ee = 1'b1; eb = 1'b0;
            push(1);
        end
        tick();
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
        tick();
    endtask

    task automatic zero_exp();
        ek = '0; er = 1'b0; ee = 1'b0; ec = 1'b1; eb = 1'b0;
    endtask

    initial begin : monitor
        logic [17:0] cur;
        logic [17:0] prev;
        exp_t        e;
        prev = 'x;
        forever begin
            @(negedge CLK);
            cur = {k, key_ready, key_err, core_rst, busy};
            if (cur !== prev) begin
                prev = cur;
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d got k=%b rdy=%b err=%b crst=%b busy=%b, required no change",
                             cyc, cur[17:4], cur[3], cur[2], cur[1], cur[0]);
                end else begin
                    e = sbq.pop_front();
                    if ((e.cyc != cyc) || (cur !== e.v)) begin
                        fails++;
                        $display("FAIL out_change got cyc=%0d k=%b rdy=%b err=%b crst=%b busy=%b, required cyc=%0d k=%b rdy=%b err=%b crst=%b busy=%b",
                                 cyc, cur[17:4], cur[3], cur[2], cur[1], cur[0],
                                 e.cyc, e.v[17:4], e.v[3], e.v[2], e.v[1], e.v[0]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        RST = 1'b1; key_start = 1'b0; key_bit_valid = 1'b0; key_bit = 1'b0; key_clear = 1'b0;
        zero_exp();
        push(1);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Good frame from IDLE.
        do_start();
        send_bits(K1, 0, 13);
        finish_parity(K1, 1'b1, 1'b1);

        // Clear in LOADED beats a simultaneous start and bit; IDLE then ignores bits.
        key_clear = 1'b1; key_start = 1'b1; key_bit_valid = 1'b1; key_bit = 1'b1;
        zero_exp();
        push(1);
        tick();
        key_clear = 1'b0; key_start = 1'b0; key_bit_valid = 1'b0; key_bit = 1'b0;
        send_bit(1'b1);
        tick();

        // Bad parity with k still zero.
        do_start();
        send_bits(K1, 0, 13);
        finish_parity(K1, 1'b0, 1'b0);

        // Good frame from ERROR, then a failed reload keeps the old key.
        do_start();
        send_bits(K1, 0, 13);
        finish_parity(K1, 1'b1, 1'b1);
        do_start();
        send_bits(K1, 0, 13);
        finish_parity(K1, 1'b0, 1'b0);

        // 7-cycle gap survives, 8-cycle gap aborts.
        do_start();
        send_bits(K2, 0, 4);
        repeat (7) tick();
        send_bits(K2, 5, 13);
        finish_parity(K2, 1'b0, 1'b1);
        do_start();
        send_bits(K2, 0, 4);
        ee = 1'b1; eb = 1'b0;
        push(8);
        repeat (11) tick();

        // Clear mid-frame together with start and a valid bit.
        do_start();
        send_bits(K1, 0, 3);
        key_clear = 1'b1; key_start = 1'b1; key_bit_valid = 1'b1; key_bit = 1'b1;
        zero_exp();
        push(1);
        tick();
        key_clear = 1'b0; key_start = 1'b0; key_bit_valid = 1'b0; key_bit = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        tick();

        // Load, restart inside SHIFT, then RST after 9 bits, then a clean frame.
        do_start();
        send_bits(K3, 0, 13);
        finish_parity(K3, 1'b1, 1'b1);
        do_start();
        send_bits(K3, 0, 2);
        do_start();
        send_bits(K1, 0, 8);
        RST = 1'b1;
        zero_exp();
        push(1);
        tick();
        RST = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        tick();
        do_start();
        send_bits(K2, 0, 13);
        finish_parity(K2, 1'b0, 1'b1);
        repeat (3) tick();
        #1;

        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_change got no change by cyc=%0d, required cyc=%0d k=%b rdy=%b err=%b crst=%b busy=%b",
                     cyc, e.cyc, e.v[17:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
